// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: Mealy enables/flushes, registered halt and perf counters.
// Data miss freezes the whole pipe (DWAIT); halt drains the back end for DRAIN cycles, then holds halt until reset.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int DRAIN = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             ex_d_ren,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rsel1,
  input  logic [4:0]       id_rsel2,
  input  logic             id_uses_rt,
  input  logic             br_taken,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             id_en,
  output logic             hz_flushed,
  output logic             en,
  output logic             flushed,
  output logic             wb_en,
  output logic             imem_ren,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN_S, HALTED} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_active;
  logic             w_dstall;
  logic             w_load_use;

  assign w_active   = (r_state == RUN) || (r_state == DWAIT);
  assign w_dstall   = dmem_req && !dhit;
  assign w_load_use = ex_d_ren && (ex_wsel != 5'd0) &&
                      ((ex_wsel == id_rsel1) || (id_uses_rt && (ex_wsel == id_rsel2)));

  always_comb begin
    w_next     = r_state;
    pc_en      = 1'b0;
    id_en      = 1'b0;
    hz_flushed = 1'b0;
    en         = 1'b0;
    flushed    = 1'b0;
    wb_en      = 1'b0;
    imem_ren   = 1'b0;
    if (RST) begin
      w_next     = RUN;
      hz_flushed = 1'b1;
      flushed    = 1'b1;
    end else begin
      case (r_state)
        RUN, DWAIT: begin
          if (w_dstall) begin
            // memory port belongs to the data access; everything freezes
            w_next = DWAIT;
          end else begin
            w_next   = halt_mem ? DRAIN_S : RUN;
            imem_ren = 1'b1;
            en       = 1'b1;
            wb_en    = 1'b1;
            if (br_taken && !halt_mem) begin
              pc_en      = 1'b1;
              id_en      = 1'b1;
              hz_flushed = 1'b1;
              flushed    = 1'b1;
            end else if (w_load_use || !ihit) begin
              hz_flushed = 1'b1;
            end else begin
              pc_en = 1'b1;
              id_en = 1'b1;
            end
          end
        end
        DRAIN_S: begin
          en         = 1'b1;
          flushed    = 1'b1;
          wb_en      = 1'b1;
          hz_flushed = 1'b1;
          if (r_drain_cnt == '0) w_next = HALTED;
        end
        default: begin
          hz_flushed = 1'b1;
          flushed    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_active && (w_next == DRAIN_S)) begin
        r_drain_cnt <= DW'(DRAIN - 1);
      end else if ((r_state == DRAIN_S) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
      if ((r_state == DRAIN_S) && (r_drain_cnt == '0)) r_halt <= 1'b1;
      if (w_active && !pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_active && flushed && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // the data request must be held until the memory acknowledges it
  a_dwait_hold: assert property (@(posedge CLK) disable iff (RST) (r_state == DWAIT) |-> dmem_req);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int DRAIN = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dmem_req, ex_d_ren, id_uses_rt, br_taken, halt_mem;
  logic [4:0] ex_wsel, id_rsel1, id_rsel2;
  logic pc_en, id_en, hz_flushed, en, flushed, wb_en, imem_ren, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  // model: halted flag, remaining drain cycles, counters, outstanding data miss
  bit m_halted = 0;
  int m_drain  = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  bit m_pend   = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .ex_d_ren(ex_d_ren), .ex_wsel(ex_wsel), .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .id_uses_rt(id_uses_rt), .br_taken(br_taken), .halt_mem(halt_mem),
    .pc_en(pc_en), .id_en(id_en), .hz_flushed(hz_flushed), .en(en), .flushed(flushed),
    .wb_en(wb_en), .imem_ren(imem_ren), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en,id_en,hz_flushed,en,flushed,wb_en,imem_ren}
  function automatic logic [6:0] model_outs();
    bit hazard;
    hazard = ex_d_ren && (ex_wsel != 0) &&
             ((ex_wsel == id_rsel1) || (id_uses_rt && (ex_wsel == id_rsel2)));
    if (RST || m_halted)               return 7'b0010100;
    if (m_drain > 0)                   return 7'b0011110;
    if (dmem_req && !dhit)             return 7'b0000000;
    if (br_taken && !halt_mem)         return 7'b1111111;
    if (hazard || !ihit)               return 7'b0011011;
    return 7'b1101011;
  endfunction

  task automatic cycle(input string tag);
    logic [6:0] e, o;
    @(negedge CLK);
    e = model_outs();
    o = {pc_en, id_en, hz_flushed, en, flushed, wb_en, imem_ren};
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s outs got=%b want=%b", tag, o, e); end
    total++;
    assert (halt === m_halted) else begin bad++; $error("FAIL %s halt got=%b want=%b", tag, halt, m_halted); end
    total++;
    assert (stall_cnt === CNT_W'(m_stall)) else begin bad++; $error("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, m_stall); end
    total++;
    assert (flush_cnt === CNT_W'(m_flush)) else begin bad++; $error("FAIL %s flush_cnt got=%0d want=%0d", tag, flush_cnt, m_flush); end
    @(posedge CLK);
    if (RST) begin
      m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0; m_pend = 0;
    end else if (m_halted) begin
      m_pend = 0;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1;
      m_pend = 0;
    end else begin
      if (!e[6] && m_stall < MAXC) m_stall++;
      if (e[2] && m_flush < MAXC) m_flush++;
      m_pend = dmem_req && !dhit;
      if (halt_mem && e[3]) m_drain = DRAIN;
    end
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 0; dmem_req = 0; ex_d_ren = 0; ex_wsel = 0;
    id_rsel1 = 0; id_rsel2 = 0; id_uses_rt = 0; br_taken = 0; halt_mem = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    @(posedge CLK); #1;
    cycle("reset0");
    cycle("reset1");
    RST = 0;
    cycle("post_reset");

    ex_d_ren = 1; ex_wsel = 8; id_rsel1 = 8;
    cycle("loaduse_rs");
    ex_d_ren = 0;
    cycle("loaduse_clear");

    ex_d_ren = 1; ex_wsel = 0; id_rsel1 = 0;
    cycle("loaduse_zero_reg");
    ex_wsel = 8; id_rsel1 = 3; id_rsel2 = 8; id_uses_rt = 0;
    cycle("loaduse_rt_unused");
    id_uses_rt = 1;
    cycle("loaduse_rt");
    idle();

    dmem_req = 1; dhit = 0;
    repeat (3) cycle("dwait");
    dhit = 1;
    cycle("dwait_hit");
    dmem_req = 0; dhit = 0;
    cycle("after_dwait");

    br_taken = 1; ihit = 0; ex_d_ren = 1; ex_wsel = 9; id_rsel1 = 9;
    cycle("branch_over_hazard");
    idle();
    cycle("after_branch");

    halt_mem = 1;
    cycle("halt_enter");
    halt_mem = 0;
    cycle("drain1");
    cycle("drain2");
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; dmem_req = i[1]; br_taken = i[2];
      cycle("halted_hold");
    end
    idle();
    RST = 1;
    cycle("halt_reset");
    RST = 0;
    cycle("halt_cleared");

    for (int i = 0; i < 800; i++) begin
      RST        = ($urandom_range(0, 79) == 0);
      ihit       = ($urandom_range(0, 3) != 0);
      dhit       = $urandom_range(0, 1);
      dmem_req   = m_pend ? 1'b1 : ($urandom_range(0, 2) == 0);
      ex_d_ren   = $urandom_range(0, 1);
      ex_wsel    = 5'($urandom_range(0, 3));
      id_rsel1   = 5'($urandom_range(0, 3));
      id_rsel2   = 5'($urandom_range(0, 3));
      id_uses_rt = $urandom_range(0, 1);
      halt_mem   = ($urandom_range(0, 49) == 0);
      br_taken   = !halt_mem && ($urandom_range(0, 4) == 0);
      cycle("random");
    end

    // long stall run with no reset to reach counter saturation
    idle();
    RST = 1;
    cycle("sat_reset");
    RST = 0; ihit = 0;
    repeat (MAXC + 3) cycle("stall_saturate");
    ihit = 1; br_taken = 1;
    repeat (MAXC + 3) cycle("flush_saturate");
    idle();
    cycle("sat_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
